// File: rtl/memory_types_pkg.sv
// Shared memory-subsystem types: arbiter FSM states and transaction owner.
package memory_types_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port fixed-latency memory.
// Data requests win ties, with a streak limit so instruction fetch cannot starve.
module mem_arbiter
   import memory_types_pkg::*;
#(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int MEM_LATENCY    = 1,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int STREAK_W = $clog2(MAX_DATA_BURST + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

   arb_state_t          state_reg, state_next;
   owner_t              owner_reg, owner_next;
   logic                we_reg, we_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   wdata_reg, wdata_next;
   logic [3:0]          wait_cnt_reg, wait_cnt_next;
   logic [STREAK_W-1:0] streak_reg, streak_next;
   logic                grant_d;
   logic                in_access;
   logic                in_resp;

   // Fetch overrides data only once data has used up its streak while fetch waited.
   assign grant_d = d_req && !(i_req && (streak_reg == STREAK_MAX));

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      we_next       = we_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      wait_cnt_next = wait_cnt_reg;
      streak_next   = streak_reg;
      case (state_reg)
         IDLE: begin
            if (!i_req) begin
               streak_next = '0;
            end
            if (i_req || d_req) begin
               state_next = ACCESS;
               if (grant_d) begin
                  owner_next = OWN_D;
                  we_next    = d_we;
                  addr_next  = d_addr;
                  wdata_next = d_wdata;
                  if (i_req && (streak_reg != STREAK_MAX)) begin
                     streak_next = streak_reg + 1'b1;
                  end
               end else begin
                  owner_next  = OWN_I;
                  we_next     = 1'b0;
                  addr_next   = i_addr;
                  wdata_next  = '0;
                  streak_next = '0;
               end
            end
         end
         ACCESS: begin
            if (MEM_LATENCY > 1) begin
               state_next    = WAIT;
               wait_cnt_next = 4'(MEM_LATENCY - 2);
            end else begin
               state_next = RESP;
            end
         end
         WAIT: begin
            if (wait_cnt_reg == 4'd0) begin
               state_next = RESP;
            end else begin
               wait_cnt_next = wait_cnt_reg - 4'd1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         owner_reg    <= OWN_I;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         wait_cnt_reg <= '0;
         streak_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         we_reg       <= we_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         wait_cnt_reg <= wait_cnt_next;
         streak_reg   <= streak_next;
      end
   end

   assign in_access = (state_reg == ACCESS);
   assign in_resp   = (state_reg == RESP);

   assign mem_en    = in_access;
   assign mem_we    = in_access && we_reg;
   assign mem_addr  = in_access ? addr_reg : '0;
   assign mem_wdata = in_access ? wdata_reg : '0;

   assign i_ready  = in_access && (owner_reg == OWN_I);
   assign d_ready  = in_access && (owner_reg == OWN_D);
   assign i_rvalid = in_resp && (owner_reg == OWN_I);
   assign d_rvalid = in_resp && (owner_reg == OWN_D);

   // Stores complete with zero data so the requester never sees stale memory output.
   assign i_rdata = i_rvalid ? mem_rdata : '0;
   assign d_rdata = (d_rvalid && !we_reg) ? mem_rdata : '0;

   assign busy = (state_reg != IDLE);

endmodule
